// File: rtl/adc_capture_array.sv
// Simultaneous-sampling capture engine for NUM_CH serial SAR ADCs sharing one SCLK.
// Optional build macro ADC_CAPTURE_TIMESTAMP_EN adds a frame-start timestamp output.
module adc_capture_array #(
  parameter int NUM_CH     = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CYC  = 8
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  ,
  parameter int TS_W       = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     single_shot,
  input  logic                     trigger,
  input  logic [NUM_CH-1:0]        sdata,
  output logic [NUM_CH-1:0]        cs_n,
  output logic                     sclk,
  output logic [NUM_CH*DATA_W-1:0] samples,
  output logic                     valid,
  input  logic                     ready,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic                     busy
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]          timestamp
`endif
);

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int QW = $clog2(QUIET_CYC + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

  // Handshake: a vector transfers on any rising edge where valid && ready;
  // valid never drops without a transfer and samples are frozen while valid.
  state_t                     state_q, state_d;
  logic [DW-1:0]              div_q, div_d;
  logic                       phase_q, phase_d;
  logic [BW-1:0]              bit_q, bit_d;
  logic [QW-1:0]              quiet_q, quiet_d;
  logic [NUM_CH-1:0]          sdata_q;
  logic [DATA_W-1:0]          shreg_q [NUM_CH];
  logic [DATA_W-1:0]          shreg_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   samples_q, samples_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;
  logic                       cs_n_q, cs_n_d;
  logic                       sclk_q, sclk_d;
  logic                       in_window;
  int                         bit_idx;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    quiet_d   = quiet_q;
    shreg_d   = shreg_q;
    samples_d = samples_q;
    valid_d   = valid_q && !ready;
    overrun_d = overrun_q && !ovr_clr;
    bit_idx   = int'(bit_q);
    in_window = (bit_idx >= LEAD_BITS) && (bit_idx < LEAD_BITS + DATA_W);

    case (state_q)
      IDLE: begin
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        if (single_shot ? trigger : enable) state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          phase_d = !phase_q;
          if (phase_q) begin
            // End of the low half: capture the bit, then SCLK rises.
            if (in_window) begin
              for (int k = 0; k < NUM_CH; k++)
                shreg_d[k] = (shreg_q[k] << 1) | DATA_W'(sdata_q[k]);
            end
            if (bit_q == BW'(FRAME_BITS - 1)) begin
              bit_d   = '0;
              state_d = DONE;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE: begin
        if (!valid_q || ready) begin
          for (int k = 0; k < NUM_CH; k++)
            samples_d[k*DATA_W +: DATA_W] = shreg_q[k];
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        // Counting down from QUIET_CYC gives QUIET_CYC+1 quiet cycles, so with
        // DONE the gap is QUIET_CYC+2 cycles.
        quiet_d = QW'(QUIET_CYC);
        state_d = QUIET;
      end
      QUIET: begin
        if (quiet_q == '0) state_d = (enable && !single_shot) ? SHIFT : IDLE;
        else               quiet_d = quiet_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    cs_n_d = (state_d != SHIFT);
    sclk_d = !((state_d == SHIFT) && phase_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      quiet_q   <= '0;
      sdata_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) shreg_q[k] <= '0;
      samples_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      quiet_q   <= quiet_d;
      sdata_q   <= sdata;
      shreg_q   <= shreg_d;
      samples_q <= samples_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
    end
  end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cap_q, timestamp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q    <= '0;
      ts_cap_q    <= '0;
      timestamp_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (state_q != SHIFT && state_d == SHIFT) ts_cap_q <= ts_cnt_q;
      if (state_q == DONE && (!valid_q || ready)) timestamp_q <= ts_cap_q;
    end
  end

  assign timestamp = timestamp_q;
`endif

  assign cs_n    = {NUM_CH{cs_n_q}};
  assign sclk    = sclk_q;
  assign samples = samples_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_adc_capture_array.sv
// Directed bench for adc_capture_array: ADC word models, expected-vector queue, handshake monitor.
module tb_adc_capture_array;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 12;
  localparam int CLK_DIV   = 2;
  localparam int QUIET_CYC = 4;
  localparam int W         = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              rst, enable, single_shot, trigger, ready, ovr_clr;
  logic [NUM_CH-1:0] sdata = '0;
  logic [NUM_CH-1:0] cs_n;
  logic              sclk, valid, overrun, busy;
  logic [W-1:0]      samples;
`ifdef ADC_CAPTURE_TIMESTAMP_EN
  logic [31:0]       timestamp;
  logic [31:0]       pop_ts[$];
`endif

  logic [15:0]       word [NUM_CH];
  logic [W-1:0]      exp_q[$];
  longint            pop_cyc[$];
  longint            cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;
  int                k_bit = 0;

  adc_capture_array #(
    .NUM_CH(NUM_CH), .FRAME_BITS(16), .LEAD_BITS(4), .DATA_W(DATA_W),
    .CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot),
    .trigger(trigger), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
    .samples(samples), .valid(valid), .ready(ready), .overrun(overrun),
    .ovr_clr(ovr_clr), .busy(busy)
`ifdef ADC_CAPTURE_TIMESTAMP_EN
    , .timestamp(timestamp)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ADC model: a new bit appears after every SCLK fall, MSB first.
  always @(negedge sclk or posedge cs_n[0]) begin
    if (cs_n[0]) begin
      k_bit = 0;
    end else if (k_bit < 16) begin
      for (int ch = 0; ch < NUM_CH; ch++) sdata[ch] = word[ch][15-k_bit];
      k_bit++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic monitor();
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && valid === 1'b1 && ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_vector: got 0x%0h expected none", samples);
        end else begin
          e = exp_q.pop_front();
          check("samples", {16'h0, samples}, {16'h0, e});
        end
        pop_cyc.push_back(cyc);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        pop_ts.push_back(timestamp);
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [15:0] w0, w1, w2, w3);
    word[0] = w0; word[1] = w1; word[2] = w2; word[3] = w3;
  endtask

  task automatic wait_cs(input logic level, input int bound, input string name);
    int n = 0;
    while (cs_n[0] !== level && n < bound) begin
      tick();
      n++;
    end
    if (cs_n[0] !== level) timeout(name);
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) timeout(name);
  endtask

  task automatic run_shot(input string name);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_cs(1'b1, 200, name);
    wait_idle(200, name);
  endtask

  initial begin
    int low;
    int nb;
    rst = 1'b1; enable = 1'b0; single_shot = 1'b0; trigger = 1'b0;
    ready = 1'b1; ovr_clr = 1'b0;
    set_words(16'h0, 16'h0, 16'h0, 16'h0);
    fork
      monitor();
    join_none
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_cs_n", cs_n, 4'hF);
    check("rst_sclk", sclk, 1'b1);
    check("rst_samples", samples, '0);
    check("rst_valid", valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Free-run, three frames, ready held high.
    set_words(16'h0ABC, 16'h0123, 16'h0FFF, 16'h0000);
    repeat (3) exp_q.push_back(48'h000_FFF_123_ABC);
    pop_cyc.delete();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_cs(1'b0, 200, "freerun_start");
      if (i < 2) wait_cs(1'b1, 200, "freerun_end");
    end
    enable = 1'b0;
    wait_idle(300, "freerun_idle");
    check("freerun_pops", pop_cyc.size(), 3);
    if (pop_cyc.size() >= 3) begin
      check("freerun_period0", pop_cyc[1] - pop_cyc[0], 70);
      check("freerun_period1", pop_cyc[2] - pop_cyc[1], 70);
`ifdef ADC_CAPTURE_TIMESTAMP_EN
      check("ts_period0", pop_ts[1] - pop_ts[0], 70);
      check("ts_period1", pop_ts[2] - pop_ts[1], 70);
`endif
    end

    // Single shot with an ignored mid-frame trigger.
    single_shot = 1'b1;
    set_words(16'h0555, 16'h0AAA, 16'h0001, 16'h0800);
    exp_q.push_back(48'h800_001_AAA_555);
    pop_cyc.delete();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check("trig_latency_cs_n", cs_n, 4'h0);
    low = 0;
    while (cs_n[0] === 1'b0 && low < 200) begin
      low++;
      trigger = (low == 20);
      tick();
    end
    trigger = 1'b0;
    check("cs_low_cycles", low, 64);
    nb = 0;
    while (busy === 1'b1 && nb < 200) begin
      nb++;
      tick();
    end
    check("busy_tail_cycles", nb, 6);
    repeat (100) tick();
    check("single_pops", pop_cyc.size(), 1);
    check("single_idle_cs_n", cs_n, 4'hF);

    // Back-pressure over two frames: first vector held, second dropped.
    ready = 1'b0;
    set_words(16'h0FED, 16'h0CBA, 16'h0987, 16'h0654);
    exp_q.push_back(48'h654_987_CBA_FED);
    run_shot("bp_frame1");
    check("bp_valid1", valid, 1'b1);
    check("bp_overrun1", overrun, 1'b0);
    set_words(16'h0111, 16'h0222, 16'h0333, 16'h0444);
    run_shot("bp_frame2");
    check("bp_held_samples", samples, 48'h654_987_CBA_FED);
    check("bp_overrun2", overrun, 1'b1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("bp_ovr_clr", overrun, 1'b0);
    ready = 1'b1;
    tick();
    tick();
    check("bp_drained_valid", valid, 1'b0);

    // Consumer accepts in the same cycle DONE loads a new vector.
    ready = 1'b0;
    set_words(16'h0A5A, 16'h05A5, 16'h0C3C, 16'h03C3);
    exp_q.push_back(48'h3C3_C3C_5A5_A5A);
    run_shot("same_frame1");
    set_words(16'h0F0F, 16'h00F0, 16'h0777, 16'h0888);
    exp_q.push_back(48'h888_777_0F0_F0F);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_cs(1'b1, 200, "same_done");
    ready = 1'b1;
    tick();
    check("same_valid_kept", valid, 1'b1);
    check("same_new_samples", samples, 48'h888_777_0F0_F0F);
    check("same_overrun", overrun, 1'b0);
    tick();
    check("same_valid_drop", valid, 1'b0);
    wait_idle(200, "same_idle");

    // Reset during bit 7 with an unconsumed vector pending.
    ready = 1'b0;
    set_words(16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
    run_shot("rst_pre_frame");
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (30) tick();
    rst = 1'b1;
    #1;
    check("midrst_cs_n", cs_n, 4'hF);
    check("midrst_sclk", sclk, 1'b1);
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    ready = 1'b1;
    tick();
    set_words(16'h0246, 16'h0135, 16'h0ACE, 16'h0BDF);
    exp_q.push_back(48'hBDF_ACE_135_246);
    run_shot("post_rst_frame");
    tick();

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
